// File: rtl/cic_interp_mc.sv
// ---------------------------------------------------------------------------
// cic_interp_mc
//   Multichannel CIC interpolator. It accepts one frame of CH time-multiplexed
//   samples. All ORDER comb stages run at the input rate, in the same cycle
//   the sample is accepted. The integrator chain then runs at the output rate
//   over RATE zero-stuffed phases, and emits RATE*CH samples per frame.
//   Channel index is the fastest-changing index in the output order.
//
// Ports
//   clk       clock
//   rst       synchronous reset, active-high
//   s_valid   input sample valid
//   s_ready   input sample accepted when s_valid & s_ready (LOAD only)
//   s_data    input sample, two's complement, IN_W bits
//   s_first   marks the channel-0 sample of a frame
//   m_valid   output sample valid
//   m_ready   downstream accepts output
//   m_data    output sample, OUT_W bits, saturated
//   m_ch      channel of m_data
//   sync_err  one-cycle pulse on frame misalignment
//
// Build option
//   CIC_ROUND_EN  defined   : output is rounded half-up before saturation
//                 undefined : output is truncated (floor) before saturation
// ---------------------------------------------------------------------------
module cic_interp_mc #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20,
    parameter int ORDER = 3,
    parameter int RATE  = 8,
    parameter int CH    = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    input  logic [IN_W-1:0]                            s_data,
    input  logic                                       s_first,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic [OUT_W-1:0]                           m_data,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0]     m_ch,
    output logic                                       sync_err
);

    localparam int LR = $clog2(RATE);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int IW = IN_W + ORDER * LR;
    localparam int SH = (ORDER - 1) * LR - (OUT_W - IN_W);
    localparam int XW = IW + 1;

    localparam logic signed [XW-1:0] SAT_MAX = {{(XW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{(XW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Elaboration-time parameter checks
    if (ORDER < 1 || ORDER > 5) begin : g_bad_order
        $error("cic_interp_mc: ORDER must be 1..5");
    end
    if (RATE < 2 || RATE > 32 || (RATE & (RATE - 1)) != 0) begin : g_bad_rate
        $error("cic_interp_mc: RATE must be a power of two in 2..32");
    end
    if (CH < 1 || CH > 8) begin : g_bad_ch
        $error("cic_interp_mc: CH must be 1..8");
    end
    if (OUT_W < IN_W) begin : g_bad_outw
        $error("cic_interp_mc: OUT_W must be >= IN_W");
    end
    if ((ORDER - 1) * LR < OUT_W - IN_W) begin : g_bad_gain
        $error("cic_interp_mc: (ORDER-1)*log2(RATE) must be >= OUT_W-IN_W");
    end

    logic [0:0]           state;
    logic [CW-1:0]        ch_cnt;
    logic [CW-1:0]        run_ch;
    logic [LR-1:0]        phase;
    logic                 done;

    logic signed [IW-1:0] comb_dly [CH][ORDER];
    logic signed [IW-1:0] integ    [CH][ORDER];
    logic signed [IW-1:0] comb_res [CH];

    // Input side: channel the accepted sample belongs to and the comb chain
    logic [CW-1:0]        in_ch;
    logic signed [IW-1:0] comb_in [ORDER];
    logic signed [IW-1:0] comb_out;

    always_comb begin
        in_ch    = s_first ? '0 : ch_cnt;
        comb_out = {{(IW - IN_W){s_data[IN_W-1]}}, s_data};
        for (int unsigned k = 0; k < ORDER; k++) begin
            comb_in[k] = comb_out;
            comb_out   = comb_out - comb_dly[in_ch][k];
        end
    end

    // Output side: integrator chain for the current slot, each stage fed by
    // the freshly updated value of the previous one
    logic signed [IW-1:0] int_new [ORDER];
    logic signed [IW-1:0] acc;
    logic signed [XW-1:0] y_ext;
    logic signed [XW-1:0] y_rnd;
    logic signed [XW-1:0] y_sh;
    logic [OUT_W-1:0]     y_out;

`ifdef CIC_ROUND_EN
    localparam int HS = (SH > 0) ? SH - 1 : 0;
    localparam logic signed [XW-1:0] HALF = (SH > 0) ? (XW'(1) << HS) : XW'(0);
`endif

    always_comb begin
        acc = (phase == '0) ? comb_res[run_ch] : '0;
        for (int unsigned k = 0; k < ORDER; k++) begin
            acc        = integ[run_ch][k] + acc;
            int_new[k] = acc;
        end
        // One guard bit so the rounding offset cannot overflow
        y_ext = {int_new[ORDER-1][IW-1], int_new[ORDER-1]};
`ifdef CIC_ROUND_EN
        y_rnd = y_ext + HALF;
`else
        y_rnd = y_ext;
`endif
        y_sh = y_rnd >>> SH;
        if (y_sh > SAT_MAX) begin
            y_out = SAT_MAX[OUT_W-1:0];
        end else if (y_sh < SAT_MIN) begin
            y_out = SAT_MIN[OUT_W-1:0];
        end else begin
            y_out = y_sh[OUT_W-1:0];
        end
    end

    always_comb begin
        s_ready = (state == ST_LOAD) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOAD;
            ch_cnt   <= '0;
            run_ch   <= '0;
            phase    <= '0;
            done     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_ch     <= '0;
            sync_err <= 1'b0;
            for (int unsigned c = 0; c < CH; c++) begin
                comb_res[c] <= '0;
                for (int unsigned k = 0; k < ORDER; k++) begin
                    comb_dly[c][k] <= '0;
                    integ[c][k]    <= '0;
                end
            end
        end else begin
            sync_err <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (s_valid) begin
                        if (!s_first && ch_cnt == '0) begin
                            // Stray sample where a frame start is expected:
                            // handshake it but leave all filter state alone
                            sync_err <= 1'b1;
                        end else begin
                            // Early s_first restarts the frame at channel 0;
                            // combs of the abandoned channels stay as they are
                            if (s_first && ch_cnt != '0) begin
                                sync_err <= 1'b1;
                            end
                            for (int unsigned k = 0; k < ORDER; k++) begin
                                comb_dly[in_ch][k] <= comb_in[k];
                            end
                            comb_res[in_ch] <= comb_out;
                            if (in_ch == CW'(CH - 1)) begin
                                ch_cnt <= '0;
                                run_ch <= '0;
                                phase  <= '0;
                                done   <= 1'b0;
                                state  <= ST_RUN;
                            end else begin
                                ch_cnt <= in_ch + 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (!m_valid || m_ready) begin
                        if (done) begin
                            // Final slot has just been handshaken
                            m_valid <= 1'b0;
                            done    <= 1'b0;
                            state   <= ST_LOAD;
                        end else begin
                            for (int unsigned k = 0; k < ORDER; k++) begin
                                integ[run_ch][k] <= int_new[k];
                            end
                            m_data  <= y_out;
                            m_ch    <= run_ch;
                            m_valid <= 1'b1;
                            if (run_ch == CW'(CH - 1)) begin
                                run_ch <= '0;
                                if (phase == LR'(RATE - 1)) begin
                                    done <= 1'b1;
                                end else begin
                                    phase <= phase + 1'b1;
                                end
                            end else begin
                                run_ch <= run_ch + 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_interp_mc.sv
// ---------------------------------------------------------------------------
// tb_cic_interp_mc
//   Self-checking bench for cic_interp_mc at default parameters. Expected
//   outputs come from a direct-form convolution of the zero-stuffed input
//   with the CIC impulse response (coefficients of (1+z^-1+...+z^-(R-1))^N).
// ---------------------------------------------------------------------------
module tb_cic_interp_mc;

    localparam int IN_W  = 16;
    localparam int OUT_W = 20;
    localparam int ORDER = 3;
    localparam int RATE  = 8;
    localparam int CH    = 2;
    localparam int SH    = 2;
    localparam int NOUT  = RATE * CH;
    localparam int HL    = ORDER * (RATE - 1) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [IN_W-1:0]  s_data = '0;
    logic             s_first = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [OUT_W-1:0] m_data;
    logic [0:0]       m_ch;
    logic             sync_err;

    always #5 clk = ~clk;

    cic_interp_mc #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .ORDER(ORDER),
        .RATE (RATE),
        .CH   (CH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_first (s_first),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_ch    (m_ch),
        .sync_err(sync_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    longint h [HL];
    longint xh [CH][64];
    int     nfr = 0;

    logic [OUT_W-1:0] od[$];
    logic [0:0]       oc[$];
    int stall_bad, srdy_bad, first_v;
    bit tmo;

    task automatic build_h();
        longint t [HL];
        int len;
        for (int i = 0; i < HL; i++) h[i] = 0;
        h[0] = 1;
        len = 1;
        for (int o = 0; o < ORDER; o++) begin
            for (int i = 0; i < HL; i++) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < RATE; j++)
                    t[i+j] += h[i];
            for (int i = 0; i < HL; i++) h[i] = t[i];
            len += RATE - 1;
        end
    endtask

    function automatic longint model_y(int c, int n);
        longint a = 0;
        for (int m = 0; m < nfr; m++) begin
            int k = n - m * RATE;
            if (k >= 0 && k < HL) a += h[k] * xh[c][m];
        end
        return a;
    endfunction

    function automatic logic [OUT_W-1:0] scale(longint y);
        longint v;
        longint vmax = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint vmin = -(longint'(1) <<< (OUT_W - 1));
`ifdef CIC_ROUND_EN
        v = (y + (longint'(1) <<< (SH - 1))) >>> SH;
`else
        v = y >>> SH;
`endif
        if (v > vmax) v = vmax;
        if (v < vmin) v = vmin;
        return v[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] exp_data(int c, int p);
        return scale(model_y(c, (nfr - 1) * RATE + p));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nfr = 0;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic first, output bit ok);
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_first = first;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    // Drains n outputs under a random m_ready pattern, recording stall and
    // s_ready behaviour for the calling test to judge
    task automatic collect(input int n, input int pct);
        logic             stalled = 1'b0;
        logic [OUT_W-1:0] pd = '0;
        logic [0:0]       pc = '0;
        od.delete();
        oc.delete();
        stall_bad = 0;
        srdy_bad  = 0;
        first_v   = 0;
        tmo       = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            m_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (od.size() < n && s_ready) srdy_bad++;
            if (stalled && (!m_valid || m_data !== pd || m_ch !== pc)) stall_bad++;
            if (m_valid && first_v == 0) first_v = cyc;
            stalled = m_valid && !m_ready;
            pd = m_data;
            pc = m_ch;
            if (m_valid && m_ready) begin
                od.push_back(m_data);
                oc.push_back(m_ch);
            end
            @(posedge clk);
            #1;
            if (od.size() >= n) begin
                tmo = 1'b0;
                break;
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic frame(input logic [IN_W-1:0] d0, input logic [IN_W-1:0] d1, input int pct);
        bit ok0, ok1;
        send(d0, 1'b1, ok0);
        send(d1, 1'b0, ok1);
        xh[0][nfr] = longint'($signed(d0));
        xh[1][nfr] = longint'($signed(d1));
        nfr++;
        collect(NOUT, pct);
        if (!ok0 || !ok1) tmo = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sready got=%b want=0", s_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        nfr = 0;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0 || sync_err !== 1'b0 || m_data !== '0 || m_ch !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b e=%b d=%h c=%b want all 0", m_valid, sync_err, m_data, m_ch);
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_sready got=%b want=1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse(input int pct, input string nm);
        logic [OUT_W-1:0] e;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            frame((f == 0) ? 16'h0100 : 16'h0000, 16'h0000, pct);
            n_cmp++;
            if (tmo || od.size() != NOUT || stall_bad != 0 || srdy_bad != 0) begin
                n_err++;
                $display("FAIL %s_flow f=%0d got n=%0d stall=%0d srdy=%0d want n=%0d 0 0", nm, f, od.size(), stall_bad, srdy_bad, NOUT);
            end
            if (f == 0 && pct == 100) begin
                n_cmp++;
                if (first_v != 2) begin
                    n_err++;
                    $display("FAIL %s_latency got=%0d want=2", nm, first_v);
                end
            end
            for (int i = 0; i < od.size(); i++) begin
                e = exp_data(i % CH, i / CH);
                n_cmp++;
                if (od[i] !== e || oc[i] !== 1'(i % CH)) begin
                    n_err++;
                    $display("FAIL %s_data f=%0d i=%0d got %h/%0d want %h/%0d", nm, f, i, od[i], oc[i], e, i % CH);
                end
                if (f == 0 && i % CH == 0) begin
                    e = OUT_W'(64 * ((i / CH + 1) * (i / CH + 2) / 2));
                    n_cmp++;
                    if (od[i] !== e) begin
                        n_err++;
                        $display("FAIL %s_known i=%0d got %h want %h", nm, i, od[i], e);
                    end
                end
            end
        end
    endtask

    task automatic test_dc();
        logic [IN_W-1:0]  v;
        logic [OUT_W-1:0] e, k;
        for (int s = 0; s < 2; s++) begin
            v = (s == 0) ? 16'h7FFF : 16'h8000;
            k = (s == 0) ? 20'h7FFF0 : 20'h80000;
            do_reset();
            for (int f = 0; f < 4; f++) begin
                frame(v, v, 100);
                n_cmp++;
                if (tmo || od.size() != NOUT) begin
                    n_err++;
                    $display("FAIL dc_count f=%0d got=%0d want=%0d", f, od.size(), NOUT);
                end
                for (int i = 0; i < od.size(); i++) begin
                    e = exp_data(i % CH, i / CH);
                    n_cmp++;
                    if (od[i] !== e || oc[i] !== 1'(i % CH)) begin
                        n_err++;
                        $display("FAIL dc_data f=%0d i=%0d got %h/%0d want %h/%0d", f, i, od[i], oc[i], e, i % CH);
                    end
                    if (f >= 2) begin
                        n_cmp++;
                        if (od[i] !== k) begin
                            n_err++;
                            $display("FAIL dc_steady f=%0d i=%0d got %h want %h", f, i, od[i], k);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_random_bp();
        logic [OUT_W-1:0] e;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            frame(IN_W'($urandom), IN_W'($urandom), 60);
            n_cmp++;
            if (tmo || od.size() != NOUT || stall_bad != 0 || srdy_bad != 0) begin
                n_err++;
                $display("FAIL rand_flow f=%0d got n=%0d stall=%0d srdy=%0d want n=%0d 0 0", f, od.size(), stall_bad, srdy_bad, NOUT);
            end
            for (int i = 0; i < od.size(); i++) begin
                e = exp_data(i % CH, i / CH);
                n_cmp++;
                if (od[i] !== e || oc[i] !== 1'(i % CH)) begin
                    n_err++;
                    $display("FAIL rand_data f=%0d i=%0d got %h/%0d want %h/%0d", f, i, od[i], oc[i], e, i % CH);
                end
            end
        end
    endtask

    task automatic test_sync();
        bit ok;
        logic [IN_W-1:0]  b, c, x;
        logic [OUT_W-1:0] e;
        logic             want_err [3] = '{1'b0, 1'b1, 1'b0};
        logic [IN_W-1:0]  dat [3];
        logic             fst [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        b = IN_W'($urandom);
        c = IN_W'($urandom);
        x = IN_W'($urandom);
        dat[0] = 16'h0000;
        dat[1] = b;
        dat[2] = c;
        // Two frame starts in a row: the zero sample is abandoned, b is ch0
        for (int j = 0; j < 3; j++) begin
            send(dat[j], fst[j], ok);
            @(negedge clk);
            n_cmp++;
            if (!ok || sync_err !== want_err[j]) begin
                n_err++;
                $display("FAIL sync_first j=%0d got ok=%0d err=%b want ok=1 err=%b", j, ok, sync_err, want_err[j]);
            end
            if (j < 2) begin
                @(posedge clk);
                #1;
            end
        end
        xh[0][nfr] = longint'($signed(b));
        xh[1][nfr] = longint'($signed(c));
        nfr++;
        collect(NOUT, 100);
        n_cmp++;
        if (tmo || od.size() != NOUT) begin
            n_err++;
            $display("FAIL sync_count got=%0d want=%0d", od.size(), NOUT);
        end
        for (int i = 0; i < od.size(); i++) begin
            e = exp_data(i % CH, i / CH);
            n_cmp++;
            if (od[i] !== e || oc[i] !== 1'(i % CH)) begin
                n_err++;
                $display("FAIL sync_data i=%0d got %h/%0d want %h/%0d", i, od[i], oc[i], e, i % CH);
            end
        end
        // Frame opening without s_first: sample is handshaken and dropped
        send(x, 1'b0, ok);
        @(negedge clk);
        n_cmp++;
        if (!ok || sync_err !== 1'b1) begin
            n_err++;
            $display("FAIL sync_stray got ok=%0d err=%b want ok=1 err=1", ok, sync_err);
        end
        @(posedge clk);
        #1;
        frame(IN_W'($urandom), IN_W'($urandom), 100);
        n_cmp++;
        if (tmo || od.size() != NOUT) begin
            n_err++;
            $display("FAIL sync_after_count got=%0d want=%0d", od.size(), NOUT);
        end
        for (int i = 0; i < od.size(); i++) begin
            e = exp_data(i % CH, i / CH);
            n_cmp++;
            if (od[i] !== e || oc[i] !== 1'(i % CH)) begin
                n_err++;
                $display("FAIL sync_after_data i=%0d got %h/%0d want %h/%0d", i, od[i], oc[i], e, i % CH);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok0, ok1;
        do_reset();
        send(16'h0100, 1'b1, ok0);
        send(16'h0000, 1'b0, ok1);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok0 || !ok1 || m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_setup got ok=%0d%0d v=%b want ok=11 v=1", ok0, ok1, m_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_rst_sready got=%b want=0", s_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        nfr = 0;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== '0) begin
            n_err++;
            $display("FAIL midrun_after got v=%b r=%b d=%h want v=0 r=1 d=0", m_valid, s_ready, m_data);
        end
        @(posedge clk);
        #1;
        test_impulse(100, "rerun");
    endtask

    task automatic test_round();
        logic [OUT_W-1:0] e;
        logic [OUT_W-1:0] k [3];
`ifdef CIC_ROUND_EN
        k = '{20'd0, 20'd1, 20'd2};
`else
        k = '{20'd0, 20'd0, 20'd1};
`endif
        do_reset();
        frame(16'h0001, 16'h0000, 100);
        n_cmp++;
        if (tmo || od.size() != NOUT) begin
            n_err++;
            $display("FAIL round_count got=%0d want=%0d", od.size(), NOUT);
        end
        for (int i = 0; i < od.size(); i++) begin
            e = exp_data(i % CH, i / CH);
            n_cmp++;
            if (od[i] !== e) begin
                n_err++;
                $display("FAIL round_data i=%0d got %h want %h", i, od[i], e);
            end
            if (i % CH == 0 && i / CH < 3) begin
                n_cmp++;
                if (od[i] !== k[i/CH]) begin
                    n_err++;
                    $display("FAIL round_known p=%0d got %0d want %0d", i / CH, od[i], k[i/CH]);
                end
            end
        end
    endtask

    initial begin
        build_h();
        test_reset();
        test_impulse(100, "impulse");
        test_dc();
        test_impulse(50, "backpressure");
        test_random_bp();
        test_sync();
        test_reset_mid_run();
        test_round();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
